// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with frame checking and scancode FIFO
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       ovf_clr,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // synchronisers: ps2_clk gets a third stage so the edge detector compares two settled samples
  logic s0, s1, s2;
  logic d0, d1;

  // frame assembly: sr holds the bits received so far, newest at the top
  logic [3:0]      cnt;
  logic [9:0]      sr;
  logic [TO_W-1:0] toc;

  logic        fall;
  logic [10:0] frame;
  logic        last_bit;
  logic        good;
  logic        push_req;

  // FIFO storage and bookkeeping
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // bring the pad lines into the clk domain; idle level of both lines is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
      d0 <= 1'b1;
      d1 <= 1'b1;
    end else begin
      s0 <= ps2_clk;
      s1 <= s0;
      s2 <= s1;
      d0 <= ps2_data;
      d1 <= d0;
    end
  end

  assign fall     = s2 & ~s1;
  // the frame as it will look once the current bit is shifted in (bit 0 = start, bit 10 = stop)
  assign frame    = {d1, sr};
  assign last_bit = fall && (cnt == 4'd10);
  assign good     = ~frame[0] & frame[10] & (^frame[9:1]);
  assign push_req = last_bit & good;

  // shift bits on each falling edge, judge the frame on the 11th, and abandon stalled frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      sr        <= 10'd0;
      toc       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= last_bit & ~good;
      if (fall) begin
        sr  <= frame[10:1];
        toc <= '0;
        cnt <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
      end else if (cnt != 4'd0) begin
        if (toc == TO_LAST) begin
          cnt <= 4'd0;
          toc <= '0;
        end else begin
          toc <= toc + TO_W'(1);
        end
      end else begin
        toc <= '0;
      end
    end
  end

  assign valid   = (count != '0);
  assign pop     = rd_en & valid;
  // a pop in the same cycle frees the slot the incoming byte needs
  assign push_ok = push_req & ((count != DEPTH_C) | pop);
  assign drop    = push_req & ~push_ok;
  assign data    = mem[rd_ptr];

  // storage needs no reset: pointers and count define which entries are live
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= frame[8:1];
    end
  end

  // pointer, occupancy and sticky overflow maintenance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard testbench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int TO = 500;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en    = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int fe_exp   = 0;
  bit fe_prev  = 1'b0;
  logic [7:0] exp_q [$];

  ps2_rx_fifo #(
    .FIFO_DEPTH(8),
    .ADDR_W(3),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rd_en(rd_en),
    .ovf_clr(ovf_clr),
    .data(data),
    .valid(valid),
    .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // scoreboard monitor: every effective pop must present the oldest expected byte
  always @(negedge clk) begin
    if (rst && rd_en && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none", data);
      end else begin
        check("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // frame_err watcher: count pulses and reject any pulse longer than one cycle
  always @(negedge clk) begin
    if (frame_err) begin
      fe_cnt++;
      if (fe_prev) begin
        checks++;
        failures++;
        $display("FAIL frame_err_width actual=2+ cycles required=1 cycle");
      end
    end
    fe_prev = frame_err;
  end

  task automatic send_bit(input bit b, input bit last, input bit pop_at_stop, input bit chk_lat,
                          input logic [7:0] byte_v);
    ps2_data = b;
    tick(4);
    ps2_clk = 1'b0;
    if (last && pop_at_stop) begin
      tick(2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(5);
    end else if (last && chk_lat) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (valid) break;
      end
      check("latency_valid", {31'd0, valid}, 32'd1);
      check("latency_data", {24'd0, data}, {24'd0, byte_v});
      tick(5);
    end else begin
      tick(8);
    end
    ps2_clk = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_at_stop, input bit chk_lat, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i], i == 10, pop_at_stop, chk_lat, b);
    end
  endtask

  task automatic pop_n(input int n);
    repeat (n) begin
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    tick(2);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    tick(3);

    // single good frame with latency check
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 0, 0, 1, 11);
    check("t1_fe", fe_cnt, fe_exp);
    pop_n(1);
    check("t1_empty", {31'd0, valid}, 32'd0);

    // three frames read back in order, then pops on an empty FIFO
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 0, 0, 0, 11);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 0, 0, 0, 0, 11);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 0, 0, 0, 11);
    check("t2_valid_full", {31'd0, valid}, 32'd1);
    pop_n(3);
    check("t2_empty", {31'd0, valid}, 32'd0);
    pop_n(2);
    check("t2_empty_extra", {31'd0, valid}, 32'd0);

    // bad parity then bad stop
    send_frame(8'h1C, 1, 0, 0, 0, 11);
    send_frame(8'h1C, 0, 1, 0, 0, 11);
    fe_exp += 2;
    check("t3_fe", fe_cnt, fe_exp);
    check("t3_valid", {31'd0, valid}, 32'd0);

    // overflow on the 9th frame, drain 1..8, clear flag
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 0, 0, 0, 0, 11);
    end
    check("t4_overflow_set", {31'd0, overflow}, 32'd1);
    pop_n(8);
    check("t4_drained", {31'd0, valid}, 32'd0);
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    check("t4_overflow_clr", {31'd0, overflow}, 32'd0);

    // full FIFO with a pop coinciding with the 9th push
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 0, 0, i == 9, 0, 11);
    end
    check("t4b_no_overflow", {31'd0, overflow}, 32'd0);
    pop_n(8);
    check("t4b_drained", {31'd0, valid}, 32'd0);
    check("t4b_sb_empty", exp_q.size(), 0);

    // partial frame abandoned by timeout, then a full frame
    send_frame(8'h55, 0, 0, 0, 0, 5);
    tick(TO + 20);
    exp_q.push_back(8'h2B);
    send_frame(8'h2B, 0, 0, 0, 0, 11);
    check("t5_fe", fe_cnt, fe_exp);
    check("t5_valid", {31'd0, valid}, 32'd1);
    pop_n(1);
    check("t5_single", {31'd0, valid}, 32'd0);

    // reset with an overflowed FIFO
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i + 8'h40), 0, 0, 0, 0, 11);
    end
    check("t6_overflow_pre", {31'd0, overflow}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    check("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(3);

    // reset mid-frame with 3 bytes queued
    send_frame(8'h11, 0, 0, 0, 0, 11);
    send_frame(8'h22, 0, 0, 0, 0, 11);
    send_frame(8'h33, 0, 0, 0, 0, 11);
    send_frame(8'h44, 0, 0, 0, 0, 4);
    rst = 1'b0;
    #1;
    check("t7_rst_valid", {31'd0, valid}, 32'd0);
    check("t7_rst_overflow", {31'd0, overflow}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(3);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 0, 0, 0, 11);
    check("t7_fe", fe_cnt, fe_exp);
    pop_n(1);
    check("t7_single", {31'd0, valid}, 32'd0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
